// File: rtl/mux8way_pkg.sv
// mux8way_pkg: shared constants and arbiter state type for the 8-way round-robin arbiter
// Contents: N_CH channel count, SEL_W select width, state_t {IDLE, GRANT}
package mux8way_pkg;
  localparam int N_CH = 8;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, GRANT} state_t;
endpackage

// File: rtl/Mux8Way.sv
// Mux8Way: existing 8-to-1 single-bit multiplexer
// Ports: in[8] data, sel[3] index, out = in[sel]
module Mux8Way (
  input  logic [7:0] in,
  input  logic [2:0] sel,
  output logic       out
);
  assign out = in[sel];
endmodule

// File: rtl/rr_pick8.sv
// rr_pick8: combinational round-robin picker, first requester at or after ptr (wrapping)
// Ports: req[8] requests, ptr[3] highest-priority channel, any = some request, idx[3] winner
import mux8way_pkg::*;
module rr_pick8 (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  always_comb begin
    any = |req;
    idx = '0;
    // scan farthest-first so the nearest requester from ptr wins
    for (int k = N_CH - 1; k >= 0; k--)
      if (req[ptr + SEL_W'(k)]) idx = ptr + SEL_W'(k);
  end
endmodule

// File: rtl/mux8way_rr_arbiter.sv
// mux8way_rr_arbiter: round-robin arbiter sharing one Mux8Way between 8 bit-serial requesters
// Ports: clk, reset (async, active-high), req[8], in[8] -> grant[8] one-hot, sel[3], busy, out
// Optional: MUX8WAY_ARB_HOLD_TIMEOUT_EN forces rotation after MAX_HOLD cycles when others wait
import mux8way_pkg::*;
module mux8way_rr_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  req,
  input  logic [N_CH-1:0]  in,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             out
);
  if (MAX_HOLD < 2 || MAX_HOLD > 256 || (2 ** CNT_W) < MAX_HOLD) begin : g_bad_cfg
    $error("mux8way_rr_arbiter: illegal MAX_HOLD/CNT_W");
  end
  state_t state;
  logic [SEL_W-1:0] ptr, arb_ptr, idx;
  logic any, rel, to, do_arb, mux_out;
`ifdef MUX8WAY_ARB_HOLD_TIMEOUT_EN
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD - 1);
  logic [CNT_W-1:0] hold_cnt;
  // grant is one-hot on sel while in GRANT, so req & ~grant is everyone else
  assign to = hold_cnt == HOLD_MAX && |(req & ~grant);
  always_ff @(posedge clk or posedge reset)
    if (reset) hold_cnt <= '0;
    else hold_cnt <= do_arb ? '0 : (hold_cnt == HOLD_MAX ? hold_cnt : hold_cnt + 1'b1);
`else
  assign to = 1'b0;
`endif
  assign rel = state == GRANT && (!req[sel] || to);
  assign do_arb = state == IDLE || rel;
  // on release the search starts just past the old owner in the same edge
  assign arb_ptr = rel ? sel + 3'd1 : ptr;
  rr_pick8 u_pick (.req(req), .ptr(arb_ptr), .any(any), .idx(idx));
  Mux8Way u_mux (.in(in), .sel(sel), .out(mux_out));
  assign out = mux_out & busy;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ptr <= '0;
      sel <= '0;
      grant <= '0;
      busy <= 1'b0;
    end else if (do_arb) begin
      if (rel) ptr <= sel + 3'd1;
      if (any) sel <= idx;
      state <= any ? GRANT : IDLE;
      busy <= any;
      grant <= any ? 8'b1 << idx : '0;
    end
endmodule

// File: tb/tb_mux8way_rr_arbiter.sv
// tb_mux8way_rr_arbiter: vector table, hand sequences and random stimulus against a reference model
module tb_mux8way_rr_arbiter;
  localparam int MH = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] req = '0, in = '0;
  logic [7:0] grant;
  logic [2:0] sel;
  logic busy, out;
  int checks = 0, errors = 0;
  int m_owner = -1, m_ptr = 0, m_sel = 0, m_hold = 0;
  typedef struct {logic [7:0] req, in, g; logic [2:0] s; logic b, o;} vec_t;
  vec_t vt[9];

  always #5 clk = ~clk;

  mux8way_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .req(req), .in(in),
    .grant(grant), .sel(sel), .busy(busy), .out(out)
  );

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_grant();
    return m_owner < 0 ? 8'h00 : 8'h01 << m_owner;
  endfunction

  function automatic void m_clear();
    m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
  endfunction

  task automatic m_edge(logic [7:0] r);
    bit timeout = 0;
`ifdef MUX8WAY_ARB_HOLD_TIMEOUT_EN
    timeout = m_owner >= 0 && m_hold == MH - 1 && (r & ~m_grant()) != 0;
`endif
    if (m_owner >= 0 && r[m_owner] && !timeout) begin
      if (m_hold < MH - 1) m_hold++;
    end else begin
      if (m_owner >= 0) m_ptr = (m_owner + 1) % 8;
      m_owner = -1;
      for (int k = 0; k < 8; k++)
        if (r[(m_ptr + k) % 8]) begin
          m_owner = (m_ptr + k) % 8;
          break;
        end
      if (m_owner >= 0) begin
        m_sel = m_owner;
        m_hold = 0;
      end
    end
  endtask

  task automatic step(logic [7:0] r, logic [7:0] d);
    req = r;
    in = d;
    @(posedge clk);
    m_edge(r);
    #1;
    chk("model_grant", grant, m_grant());
    chk("model_sel", {5'd0, sel}, 8'(m_sel));
    chk("model_busy", {7'd0, busy}, {7'd0, m_owner >= 0});
    chk("model_out", {7'd0, out}, {7'd0, m_owner >= 0 && d[m_sel]});
  endtask

  task automatic hard_reset();
    @(negedge clk);
    reset = 1'b1;
    m_clear();
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [7:0] r, e;
    vt[0] = '{8'b0010_0100, 8'h04, 8'h04, 3'd2, 1'b1, 1'b1};
    vt[1] = '{8'b0010_0000, 8'h00, 8'h20, 3'd5, 1'b1, 1'b0};
    vt[2] = '{8'b0000_0011, 8'h01, 8'h01, 3'd0, 1'b1, 1'b1};
    vt[3] = '{8'b0000_0011, 8'h02, 8'h01, 3'd0, 1'b1, 1'b0};
    vt[4] = '{8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0};
    vt[5] = '{8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1};
    vt[6] = '{8'h00, 8'h08, 8'h00, 3'd3, 1'b0, 1'b0};
    vt[7] = '{8'h80, 8'h80, 8'h80, 3'd7, 1'b1, 1'b1};
    vt[8] = '{8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0};
    req = 8'hFF;
    in = 8'hFF;
    #12;
    chk("rst_grant", grant, 8'h00);
    chk("rst_sel", {5'd0, sel}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_out", {7'd0, out}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    m_clear();
    step(8'hFF, 8'hFF);
    chk("first_grant", grant, 8'h01);
    chk("first_sel", {5'd0, sel}, 8'h00);

    hard_reset();
    for (int i = 0; i < 9; i++) begin
      step(vt[i].req, vt[i].in);
      chk($sformatf("vec%0d_grant", i), grant, vt[i].g);
      chk($sformatf("vec%0d_sel", i), {5'd0, sel}, {5'd0, vt[i].s});
      chk($sformatf("vec%0d_busy", i), {7'd0, busy}, {7'd0, vt[i].b});
      chk($sformatf("vec%0d_out", i), {7'd0, out}, {7'd0, vt[i].o});
    end

    hard_reset();
    for (int n = 0; n < 40; n++) begin
      step(8'h08, 8'(n));
      chk("single_grant", grant, 8'h08);
      chk("single_busy", {7'd0, busy}, 8'h01);
    end
    step(8'h00, 8'hFF);
    chk("single_drop_grant", grant, 8'h00);
    chk("single_drop_busy", {7'd0, busy}, 8'h00);
    chk("single_drop_sel", {5'd0, sel}, 8'h03);

    hard_reset();
    for (int n = 1; n <= 20; n++) begin
      step(8'h03, 8'h00);
`ifdef MUX8WAY_ARB_HOLD_TIMEOUT_EN
      e = ((n - 1) / MH) % 2 == 1 ? 8'h02 : 8'h01;
`else
      e = 8'h01;
`endif
      chk($sformatf("hold_grant_n%0d", n), grant, e);
    end

    hard_reset();
    step(8'h10, 8'h10);
    chk("pre_async_grant", grant, 8'h10);
    chk("pre_async_out", {7'd0, out}, 8'h01);
    #3 reset = 1'b1;
    #1;
    chk("async_grant", grant, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'h00);
    chk("async_out", {7'd0, out}, 8'h00);
    m_clear();
    #2 reset = 1'b0;

    r = 8'h00;
    for (int n = 0; n < 400; n++) begin
      r = r ^ 8'($urandom & $urandom & $urandom);
      step(r, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
